imem_loader: RTL and testbench

Byte-stream program loader that writes the processor's byte-wide instruction memory at run time, replacing the fixed image loaded on reset. It accepts a framed byte stream over a valid/ready handshake, writes each payload byte to consecutive memory addresses starting at 0, and checks a trailing XOR checksum. While a load is in progress it holds the pipeline through `cpu_hold`. Its write port drives the same 1024-byte, big-endian (MSB byte at lowest address) instruction array that the fetch stage reads.

---
 rtl/imem_loader.sv | 141 ++++++++++++++
 tb/tb_imem_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream loader for the byte-wide instruction memory.
// Frame: LEN_HI, LEN_LO (word count N), 4*N payload bytes, XOR checksum byte.
// Payload bytes are written to consecutive addresses starting at 0. The
// processor is held while a load is in flight or after an aborted load.
module imem_loader #(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [15:0]       words_loaded
);

  // One spare bit so the byte counter can also hold MEM_BYTES itself.
  localparam int CNT_W = $clog2(MEM_BYTES) + 1;

  typedef enum logic [2:0] {
    IDLE,
    S_LENH,
    S_LENL,
    S_DATA,
    S_CHK,
    DONE,
    ERR
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       len_hi;
  logic [15:0]      len_words;    // N of the frame in progress
  logic [CNT_W-1:0] byte_cnt;     // address of the next payload byte
  logic [CNT_W-1:0] last_idx;     // address of the final payload byte, 4*N-1
  logic [7:0]       csum;         // running XOR of payload bytes

  logic             xfer;
  logic             start_ok;
  logic [15:0]      len_frame;    // N as formed from the current LEN_LO byte
  logic [17:0]      len_bytes;    // 4*N, wide enough for N = 0xFFFF
  logic             len_overflow;

  assign xfer         = byte_valid && byte_ready;
  assign start_ok     = start && (state inside {IDLE, DONE, ERR});
  assign len_frame    = {len_hi, byte_in};
  assign len_bytes    = {len_frame, 2'b00};
  assign len_overflow = len_bytes > 18'(MEM_BYTES);

  // Next-state decode of the load sequencer.
  always_comb begin
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) state_nxt = S_LENH;
      S_LENH:          if (xfer) state_nxt = S_LENL;
      S_LENL: begin
        if (xfer) begin
          if (len_overflow)         state_nxt = ERR;
          else if (len_frame == '0) state_nxt = S_CHK;
          else                      state_nxt = S_DATA;
        end
      end
      S_DATA:          if (xfer && (byte_cnt == last_idx)) state_nxt = S_CHK;
      S_CHK:           if (xfer) state_nxt = (byte_in == csum) ? DONE : ERR;
      default:         state_nxt = IDLE;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      byte_ready   <= 1'b0;
      cpu_hold     <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      len_hi       <= '0;
      len_words    <= '0;
      byte_cnt     <= '0;
      last_idx     <= '0;
      csum         <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout so every register samples pre-edge values.
      state      <= state_nxt;
      byte_ready <= state_nxt inside {S_LENH, S_LENL, S_DATA, S_CHK};
      cpu_hold   <= state_nxt inside {S_LENH, S_LENL, S_DATA, S_CHK, ERR};
      mem_we     <= (state == S_DATA) && xfer;

      if (start_ok) begin
        done     <= 1'b0;
        error    <= 1'b0;
        byte_cnt <= '0;
        csum     <= '0;
      end

      case (state)
        S_LENH: if (xfer) len_hi <= byte_in;
        S_LENL: begin
          if (xfer) begin
            len_words <= len_frame;
            last_idx  <= CNT_W'(len_bytes - 18'd1);
            // Overflow aborts before any payload byte is written.
            if (len_overflow) error <= 1'b1;
          end
        end
        S_DATA: begin
          if (xfer) begin
            mem_addr  <= ADDR_W'(byte_cnt);
            mem_wdata <= byte_in;
            byte_cnt  <= byte_cnt + 1'b1;
            csum      <= csum ^ byte_in;
          end
        end
        S_CHK: begin
          if (xfer) begin
            if (byte_in == csum) begin
              done         <= 1'b1;
              words_loaded <= len_words;
            end else begin
              error <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed, table-driven bench for imem_loader.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_hold;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  imem_loader #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .byte_ready   (byte_ready),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Write log captured away from the active edge.
  int         wr_addr[$];
  logic [7:0] wr_data[$];
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_addr.push_back(int'(mem_addr));
      wr_data.push_back(mem_wdata);
    end
  end

  typedef struct {
    string      name;
    logic [7:0] b [0:11];
    int         n;
    logic       e_done;
    logic       e_err;
    logic       e_hold;
    logic [15:0] e_words;
    int         e_wr;
  } vec_t;

  vec_t vt [0:3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Offers one byte; returns ok=0 if the loader never became ready.
  task automatic send_byte(input logic [7:0] b, output bit ok);
    int t;
    byte_valid = 1'b1;
    byte_in    = b;
    t = 0;
    while (byte_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (byte_ready === 1'b1) begin
      @(posedge clk);
      @(negedge clk);
      ok = 1'b1;
    end else begin
      ok = 1'b0;
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_we"},    32'(mem_we),     32'd0);
    check({tag, "_addr"},  mem_addr,        32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata),  32'd0);
    check({tag, "_hold"},  32'(cpu_hold),   32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_err"},   32'(error),      32'd0);
    check({tag, "_words"}, 32'(words_loaded), 32'd0);
  endtask

  // Checks flags at the cycle after the last byte, then the write log.
  task automatic check_result(input vec_t v);
    check({v.name, "_done"},  32'(done),         32'(v.e_done));
    check({v.name, "_err"},   32'(error),        32'(v.e_err));
    check({v.name, "_hold"},  32'(cpu_hold),     32'(v.e_hold));
    check({v.name, "_words"}, 32'(words_loaded), 32'(v.e_words));
    @(negedge clk);
    check({v.name, "_nwr"}, 32'(wr_addr.size()), 32'(v.e_wr));
    for (int i = 0; i < v.e_wr && i < wr_addr.size(); i++) begin
      check({v.name, "_waddr"}, 32'(wr_addr[i]), 32'(i));
      check({v.name, "_wdata"}, 32'(wr_data[i]), 32'(v.b[2 + i]));
    end
  endtask

  task automatic run_frame(input vec_t v);
    bit ok;
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    check({v.name, "_rdy_after_start"},  32'(byte_ready), 32'd1);
    check({v.name, "_hold_after_start"}, 32'(cpu_hold),   32'd1);
    for (int i = 0; i < v.n; i++) begin
      send_byte(v.b[i], ok);
      check({v.name, "_accept"}, 32'(ok), 32'd1);
    end
    check_result(v);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit         ok;
    int         bad_wr;
    logic [7:0] pay;

    vt[0] = '{name: "good",
              b: '{8'h00, 8'h02, 8'h80, 8'h20, 8'h00, 8'h0A, 8'h0C, 8'h60, 8'h08, 8'h00, 8'hCE, 8'h00},
              n: 11, e_done: 1'b1, e_err: 1'b0, e_hold: 1'b0, e_words: 16'd2, e_wr: 8};
    vt[1] = '{name: "badcs",
              b: '{8'h00, 8'h02, 8'h80, 8'h20, 8'h00, 8'h0A, 8'h0C, 8'h60, 8'h08, 8'h00, 8'hCF, 8'h00},
              n: 11, e_done: 1'b0, e_err: 1'b1, e_hold: 1'b1, e_words: 16'd2, e_wr: 8};
    vt[2] = '{name: "zero",
              b: '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              n: 3, e_done: 1'b1, e_err: 1'b0, e_hold: 1'b0, e_words: 16'd0, e_wr: 0};
    vt[3] = '{name: "ovf",
              b: '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
              n: 2, e_done: 1'b0, e_err: 1'b1, e_hold: 1'b1, e_words: 16'd0, e_wr: 0};

    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    #1;
    check_reset_values("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // Bytes offered in IDLE are not consumed.
    byte_valid = 1'b1;
    byte_in    = 8'h55;
    repeat (2) @(negedge clk);
    check("idle_ready", 32'(byte_ready), 32'd0);
    byte_valid = 1'b0;

    for (int k = 0; k < 4; k++) run_frame(vt[k]);

    // After a length overflow the loader refuses further bytes.
    send_byte(8'hAA, ok);
    check("ovf_no_accept", 32'(ok), 32'd0);
    check("ovf_err_held",  32'(error), 32'd1);
    check("ovf_nwr_after", 32'(wr_addr.size()), 32'd0);

    // Maximum legal length: 256 words fill all 1024 bytes; XOR of the
    // payload (0..255 four times) is 0x00.
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    send_byte(8'h01, ok);
    send_byte(8'h00, ok);
    for (int i = 0; i < 1024; i++) begin
      pay = 8'(i);
      send_byte(pay, ok);
    end
    send_byte(8'h00, ok);
    check("max_done",  32'(done),         32'd1);
    check("max_words", 32'(words_loaded), 32'd256);
    @(negedge clk);
    check("max_nwr", 32'(wr_addr.size()), 32'd1024);
    bad_wr = 0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      pay = 8'(i);
      if (wr_addr[i] != i || wr_data[i] !== pay) bad_wr++;
    end
    check("max_wr_errors", 32'(bad_wr), 32'd0);

    // Gapped valid with a stray start in mid-frame.
    wr_addr.delete();
    wr_data.delete();
    pulse_start();
    for (int i = 0; i < vt[0].n; i++) begin
      @(negedge clk);
      if (i == 4) pulse_start();
      send_byte(vt[0].b[i], ok);
    end
    vt[0].name = "gap";
    check_result(vt[0]);

    // Reset in mid-frame, then a full good load restarting at address 0.
    pulse_start();
    for (int i = 0; i < 5; i++) send_byte(vt[0].b[i], ok);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    check_reset_values("midrst_hold");
    rst = 1'b1;
    vt[0].name = "after_rst";
    run_frame(vt[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
